// File: rtl/hilo_sequencer.sv
// Sequences one MULT/DIV at a time into the HI/LO registers, with divide-by-zero and timeout exceptions.
// Latency: go lines high the cycle after op_start until the selected done; HI/LO valid one cycle after done.
// Backpressure: busy is high from the first RUN cycle through WRITE/EXCP; op_start while busy is dropped.
module hilo_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mult_go,
    output logic        div_go,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic        div_zero,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        div0_exc,
    output logic        timeout_exc
);

    typedef enum logic [1:0] {IDLE, RUN, WRITE, EXCP} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [31:0] unit_a_q, unit_a_d;
    logic [31:0] unit_b_q, unit_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        mult_go_q, mult_go_d;
    logic        div_go_q, div_go_d;
    logic        busy_q, busy_d;
    logic        div0_q, div0_d;
    logic        timeout_q, timeout_d;
    logic        sel_done;
    logic [5:0]  cnt_inc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        unit_a_d  = unit_a_q;
        unit_b_d  = unit_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mult_go_d = mult_go_q;
        div_go_d  = div_go_q;
        div0_d    = 1'b0;
        timeout_d = 1'b0;
        sel_done  = sel_q ? div_done : mult_done;
        cnt_inc   = cnt_q + 6'd1;

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    unit_a_d  = rs_val;
                    unit_b_d  = rt_val;
                    sel_d     = op_sel;
                    cnt_d     = 6'd0;
                    mult_go_d = ~op_sel;
                    div_go_d  = op_sel;
                    state_d   = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (sel_done) begin
                    mult_go_d = 1'b0;
                    div_go_d  = 1'b0;
                    if (sel_q && div_zero) begin
                        div0_d  = 1'b1;
                        state_d = EXCP;
                    end else begin
                        hi_d    = sel_q ? div_hi : mult_hi;
                        lo_d    = sel_q ? div_lo : mult_lo;
                        state_d = WRITE;
                    end
                end else if (cnt_inc == 6'd63) begin
                    // Counter reaches 63 at this edge: the 63rd RUN cycle gave no result.
                    mult_go_d = 1'b0;
                    div_go_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = EXCP;
                end
            end
            WRITE:   state_d = IDLE;
            EXCP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            sel_q     <= 1'b0;
            unit_a_q  <= 32'd0;
            unit_b_q  <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            mult_go_q <= 1'b0;
            div_go_q  <= 1'b0;
            busy_q    <= 1'b0;
            div0_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            unit_a_q  <= unit_a_d;
            unit_b_q  <= unit_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mult_go_q <= mult_go_d;
            div_go_q  <= div_go_d;
            busy_q    <= busy_d;
            div0_q    <= div0_d;
            timeout_q <= timeout_d;
        end
    end

    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign mult_go     = mult_go_q;
    assign div_go      = div_go_q;
    assign busy        = busy_q;
    assign div0_exc    = div0_q;
    assign timeout_exc = timeout_q;

endmodule
